// File: rtl/serial_add_arbiter.sv
// Round-robin front end that time-shares one serial_adder among NREQ clients:
// latches the winner's operands, kicks the adder, waits out its latency, returns the sum.
//
// state   | meaning
// S_IDLE  | waiting for any req; picks the next winner from ptr
// S_START | one-cycle adder_start pulse, latency counter cleared
// S_RUN   | counting out the adder latency
// S_DONE  | done pulse for the granted requester, pointer advanced
module serial_add_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int LAT   = WIDTH + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_in,
    input  logic [NREQ*WIDTH-1:0]   b_in,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [WIDTH:0]          result,
    output logic                    busy,
    output logic                    adder_start,
    output logic [WIDTH-1:0]        adder_a,
    output logic [WIDTH-1:0]        adder_b,
    input  logic [WIDTH:0]          adder_sum
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(LAT - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] idx;
    logic [CNTW-1:0] cnt;

    logic [IDXW-1:0] pick_idx;
    logic            pick_vld;

    // Modular add that also works when NREQ is not a power of two.
    function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDXW'(s);
    endfunction

    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_vld && req[wrap_idx(ptr, k)]) begin
                pick_idx = wrap_idx(ptr, k);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            idx         <= '0;
            cnt         <= '0;
            gnt         <= '0;
            done        <= '0;
            busy        <= 1'b0;
            adder_start <= 1'b0;
            adder_a     <= '0;
            adder_b     <= '0;
            result      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        idx         <= pick_idx;
                        adder_a     <= a_in[int'(pick_idx)*WIDTH +: WIDTH];
                        adder_b     <= b_in[int'(pick_idx)*WIDTH +: WIDTH];
                        gnt         <= ONE_HOT0 << pick_idx;
                        adder_start <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    adder_start <= 1'b0;
                    cnt         <= '0;
                    state       <= S_RUN;
                end
                S_RUN: begin
                    if (cnt == CNT_LAST) begin
                        result <= adder_sum;
                        done   <= gnt;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= '0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= wrap_idx(idx, 1);
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter with a behavioural serial adder and a
// scoreboard queue of expected (requester, sum) completions.
module tb_serial_add_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int LAT   = 10;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH:0]        result;
    logic                  busy;
    logic                  adder_start;
    logic [WIDTH-1:0]      adder_a;
    logic [WIDTH-1:0]      adder_b;
    logic [WIDTH:0]        adder_sum;

    serial_add_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .a_in        (a_in),
        .b_in        (b_in),
        .gnt         (gnt),
        .done        (done),
        .result      (result),
        .busy        (busy),
        .adder_start (adder_start),
        .adder_a     (adder_a),
        .adder_b     (adder_b),
        .adder_sum   (adder_sum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural adder: garbage until LAT-1 edges after the start edge.
    logic [WIDTH:0] pend;
    int             acnt;
    always @(posedge clk) begin
        if (rst) begin
            adder_sum <= '0;
            pend      <= '0;
            acnt      <= 0;
        end else if (adder_start) begin
            pend      <= {1'b0, adder_a} + {1'b0, adder_b};
            adder_sum <= 9'h1AA;
            acnt      <= LAT - 1;
        end else if (acnt > 0) begin
            acnt <= acnt - 1;
            if (acnt == 1) adder_sum <= pend;
        end
    end

    typedef struct {
        int             idx;
        logic [WIDTH:0] sum;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int idx, input logic [WIDTH:0] sum);
        exp_t e;
        e.idx = idx;
        e.sum = sum;
        sb_q.push_back(e);
    endtask

    // Monitor: grant timing, start pulse and completions against the scoreboard.
    initial begin
        logic [NREQ-1:0] prev_gnt;
        int              grant_cyc;
        exp_t            e;
        prev_gnt  = '0;
        grant_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (gnt != 0 && prev_gnt == 0) begin
                    grant_cyc = cyc;
                    check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
                    check("start_with_grant", 32'(adder_start), 32'd1);
                    check("busy_with_grant", 32'(busy), 32'd1);
                end else if (adder_start) begin
                    check("stray_adder_start", 32'(adder_start), 32'd0);
                end
                if (done != 0) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("done_vector", 32'(done), 32'd1 << e.idx);
                        check("result", 32'(result), 32'(e.sum));
                        check("done_latency", 32'(cyc - grant_cyc), 32'(LAT + 1));
                        check("gnt_during_done", 32'(gnt), 32'(done));
                    end
                end
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(adder_start), 32'd0);
        check("rst_adder_a", 32'(adder_a), 32'd0);
        check("rst_adder_b", 32'(adder_b), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_grant();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (|gnt) seen = 1'b1;
        end
        check("grant_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_done(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n * (LAT + 3) + 20 && seen < n; i++) begin
            @(negedge clk);
            if (|done) seen++;
        end
        req = '0;
        check("ops_completed", 32'(seen), 32'(n));
        repeat (2) @(negedge clk);
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        a_in[i*WIDTH +: WIDTH] = a;
        b_in[i*WIDTH +: WIDTH] = b;
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        @(negedge clk);
        do_reset();

        // single request on slot 2
        set_ops(2, 8'd100, 8'd200);
        push(2, 9'd300);
        req = 4'b0100;
        wait_done(1);

        // all four held: 0,1,2,3,0
        do_reset();
        set_ops(0, 8'd17,  8'd25);
        set_ops(1, 8'd128, 8'd127);
        set_ops(2, 8'd200, 8'd100);
        set_ops(3, 8'd99,  8'd250);
        push(0, 9'd42);
        push(1, 9'd255);
        push(2, 9'd300);
        push(3, 9'd349);
        push(0, 9'd42);
        req = 4'b1111;
        wait_done(5);

        // slots 0 and 3 held: strict alternation
        do_reset();
        set_ops(0, 8'd5,   8'd6);
        set_ops(3, 8'd250, 8'd7);
        for (int k = 0; k < 4; k++) begin
            push(0, 9'd11);
            push(3, 9'd257);
        end
        req = 4'b1001;
        wait_done(8);

        // reset while RUN has cnt=5: no done, pointer back to 0
        req = 4'b0100;
        wait_grant();
        req = '0;
        repeat (6) @(negedge clk);
        do_reset();
        repeat (15) @(negedge clk);
        push(3, 9'd257);
        req = 4'b1000;
        wait_done(1);
        push(0, 9'd11);
        req = 4'b1111;
        wait_done(1);

        // req[1] dropped one cycle after its grant
        push(1, 9'd255);
        req = 4'b0010;
        wait_grant();
        @(negedge clk);
        req = '0;
        wait_done(1);

        // carry-out and zero
        set_ops(2, 8'd255, 8'd255);
        push(2, 9'd510);
        req = 4'b0100;
        wait_done(1);
        set_ops(2, 8'd0, 8'd0);
        push(2, 9'd0);
        req = 4'b0100;
        wait_done(1);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
